// File: rtl/wght_pkg.sv
// ---------------------------------------------------------------------------
// wght_pkg
// Shared definitions for the weight update unit (wght_upd).
//   - state_t    : FSM state encoding (IDLE, FETCH, MULT, WRITE, CLEAR, DONE)
//   - FXP_*      : fixed-point constants for the default Q8.24 format
//   - fxp_reduce : narrows a wide signed intermediate to a w-bit signed value
//
// Optional feature macro: WGHT_UPD_SAT_EN
//   defined   -> fxp_reduce clamps to [-2^(w-1), 2^(w-1)-1]
//   undefined -> fxp_reduce keeps the low w bits (two's-complement wrap)
// ---------------------------------------------------------------------------
package wght_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_MULT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CLEAR = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int WIDTH_DEF = 32;
  localparam int FRAC_DEF  = 24;

  // Wide enough to hold a full 2*WIDTH product plus sign headroom for any
  // supported WIDTH (up to 64).
  localparam int EXT_W = 256;

  localparam logic signed [WIDTH_DEF-1:0] FXP_ONE = WIDTH_DEF'(1) << FRAC_DEF;
  localparam logic signed [WIDTH_DEF-1:0] FXP_MAX = {1'b0, {(WIDTH_DEF-1){1'b1}}};
  localparam logic signed [WIDTH_DEF-1:0] FXP_MIN = {1'b1, {(WIDTH_DEF-1){1'b0}}};

  // Reduce a sign-extended EXT_W value to a w-bit signed result, returned
  // sign-extended to EXT_W so callers simply take the low w bits.
  function automatic logic signed [EXT_W-1:0] fxp_reduce(
    input logic signed [EXT_W-1:0] x,
    input int unsigned             w
  );
    logic signed [EXT_W-1:0] res;
`ifdef WGHT_UPD_SAT_EN
    logic signed [EXT_W-1:0] hi;
    logic signed [EXT_W-1:0] lo;
    hi = ({{(EXT_W-1){1'b0}}, 1'b1} << (w - 1)) - 1;
    lo = -hi - 1;
    if (x > hi)
      res = hi;
    else if (x < lo)
      res = lo;
    else
      res = x;
`else
    int unsigned sh;
    sh  = EXT_W - w;
    res = (x <<< sh) >>> sh;
`endif
    return res;
  endfunction

endpackage

// File: rtl/wght_upd_alu.sv
// ---------------------------------------------------------------------------
// wght_upd_alu
// Purely combinational arithmetic for the weight update w <- w - lr*grad.
//   lr, grad : signed Q(WIDTH-FRAC).FRAC operands for the MULT stage
//   prod_nxt : reduce((lr*grad) >>> FRAC), floor rounding (arithmetic shift)
//   w, prod  : current weight and registered product for the WRITE stage
//   w_nxt    : reduce(w - prod)
// Reduction behaviour follows macro WGHT_UPD_SAT_EN (see wght_pkg).
// ---------------------------------------------------------------------------
module wght_upd_alu
  import wght_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic [WIDTH-1:0] lr,
  input  logic [WIDTH-1:0] grad,
  input  logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] prod,
  output logic [WIDTH-1:0] prod_nxt,
  output logic [WIDTH-1:0] w_nxt
);

  logic signed [2*WIDTH-1:0] full;
  logic signed [2*WIDTH-1:0] shifted;
  logic signed [EXT_W-1:0]   shifted_ext;
  logic signed [EXT_W-1:0]   diff_ext;

  // Full-precision signed product, then drop FRAC bits toward -infinity.
  always_comb begin
    full        = $signed({{WIDTH{lr[WIDTH-1]}}, lr}) * $signed({{WIDTH{grad[WIDTH-1]}}, grad});
    shifted     = full >>> FRAC;
    shifted_ext = {{(EXT_W-2*WIDTH){shifted[2*WIDTH-1]}}, shifted};
    prod_nxt    = WIDTH'(fxp_reduce(shifted_ext, WIDTH));
  end

  // Subtraction is done wide so the overflow is visible to the reducer.
  always_comb begin
    diff_ext = {{(EXT_W-WIDTH){w[WIDTH-1]}}, w} - {{(EXT_W-WIDTH){prod[WIDTH-1]}}, prod};
    w_nxt    = WIDTH'(fxp_reduce(diff_ext, WIDTH));
  end

endmodule

// File: rtl/wght_upd.sv
// ---------------------------------------------------------------------------
// wght_upd
// Weight update unit. On i_start it walks idx = 0..N-1, fetching each
// accumulated gradient over a valid/ready handshake, applies
// w[idx] <- w[idx] - lr*grad in signed fixed point, then pulses o_acc_clr
// and o_done.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   i_start, i_lr      start request (IDLE only) and learning rate
//   i_grad, i_grad_vld gradient stream; o_grad_rdy / o_grad_idx handshake
//   i_init_we/addr/w   initial weight write (IDLE only, addr >= N dropped)
//   i_rd_addr, o_rd_w  combinational weight read (0 when addr >= N)
//   o_busy             high whenever not IDLE
//   o_done, o_acc_clr  one-cycle pulses at the end of a pass
//
// Optional feature macro: WGHT_UPD_SAT_EN (saturating reduce in the ALU).
// ---------------------------------------------------------------------------
module wght_upd
  import wght_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24,
  parameter int N     = 8,
  localparam int AW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_lr,
  input  logic [WIDTH-1:0] i_grad,
  input  logic             i_grad_vld,
  output logic             o_grad_rdy,
  output logic [AW-1:0]    o_grad_idx,
  input  logic             i_init_we,
  input  logic [AW-1:0]    i_init_addr,
  input  logic [WIDTH-1:0] i_init_w,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_w,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_acc_clr
);

  state_t           state;
  state_t           state_nxt;
  logic [AW-1:0]    idx;
  logic [WIDTH-1:0] lr_q;
  logic [WIDTH-1:0] grad_q;
  logic [WIDTH-1:0] prod_q;
  logic [WIDTH-1:0] bank [N];

  logic [WIDTH-1:0] prod_nxt;
  logic [WIDTH-1:0] w_nxt;
  logic             last_idx;
  logic             init_ok;
  logic             rd_ok;

  assign last_idx = (idx == AW'(N - 1));
  assign init_ok  = (32'(i_init_addr) < N);
  assign rd_ok    = (32'(i_rd_addr) < N);

  wght_upd_alu #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_alu (
    .lr       (lr_q),
    .grad     (grad_q),
    .w        (bank[idx]),
    .prod     (prod_q),
    .prod_nxt (prod_nxt),
    .w_nxt    (w_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and status outputs; idx only advances in WRITE, so the
  // requested index is stable for the whole FETCH wait.
  always_comb begin
    state_nxt  = state;
    o_grad_rdy = 1'b0;
    o_busy     = 1'b1;
    o_done     = 1'b0;
    o_acc_clr  = 1'b0;
    case (state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start)
          state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        o_grad_rdy = 1'b1;
        if (i_grad_vld)
          state_nxt = ST_MULT;
      end
      ST_MULT:  state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = last_idx ? ST_CLEAR : ST_FETCH;
      ST_CLEAR: begin
        o_acc_clr = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_done    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        o_busy    = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath registers and weight bank. An init write and a start in the
  // same IDLE cycle both take effect, so index 0 sees the new value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx    <= '0;
      lr_q   <= '0;
      grad_q <= '0;
      prod_q <= '0;
      for (int i = 0; i < N; i++)
        bank[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_init_we && init_ok)
            bank[i_init_addr] <= i_init_w;
          if (i_start) begin
            lr_q <= i_lr;
            idx  <= '0;
          end
        end
        ST_FETCH: begin
          if (i_grad_vld)
            grad_q <= i_grad;
        end
        ST_MULT: prod_q <= prod_nxt;
        ST_WRITE: begin
          bank[idx] <= w_nxt;
          if (!last_idx)
            idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_grad_idx = idx;
  assign o_rd_w     = rd_ok ? bank[i_rd_addr] : '0;

endmodule

// File: doc/wght_upd.md
Name: wght_upd

Overview:
Weight update unit; the consumer end of the weight-gradient accumulators.
- After a training batch it fetches each accumulated gradient sequentially over a valid/ready handshake.
- Applies w <- w - lr*grad in signed fixed point and stores the result in an internal N-entry weight bank.
- Finally pulses a clear to the accumulators.
- Sits between the gradient accumulator bank and the forward-path weight consumers.

Parameters:
WIDTH, 32, word width of weights, gradients and learning rate (signed two's complement)
FRAC, 24, fractional bits (Q(WIDTH-FRAC).FRAC)
N, 8, number of weights in the bank; AW = max(1, clog2(N)) is a derived localparam

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset (low = reset)
i_start  input  1  one-cycle request to begin an update pass; honoured only in IDLE
i_lr  input  WIDTH  learning rate; registered on the accepted i_start
i_grad  input  WIDTH  accumulated gradient for index o_grad_idx
i_grad_vld  input  1  i_grad valid
o_grad_rdy  output  1  unit ready to take i_grad; transfer when vld&rdy
o_grad_idx  output  AW  index of the gradient currently requested (accumulator select)
i_init_we  input  1  write initial weight; honoured only in IDLE
i_init_addr  input  AW  init write address
i_init_w  input  WIDTH  init write data
i_rd_addr  input  AW  combinational weight read address
o_rd_w  output  WIDTH  weight[i_rd_addr]; 0 if i_rd_addr >= N
o_busy  output  1  high in every state except IDLE
o_done  output  1  one-cycle pulse at pass end
o_acc_clr  output  1  one-cycle pulse telling accumulators to zero

Behaviour:
- Reset (rst low, async):
  - FSM enters IDLE; all weights, idx, lr and product registers clear to 0.
  - o_grad_rdy, o_busy, o_done and o_acc_clr are 0; o_grad_idx is 0.
- FSM states: IDLE, FETCH, MULT, WRITE, CLEAR, DONE.
- IDLE -> FETCH on i_start. Latch i_lr; set idx = 0.
- FETCH: o_grad_rdy = 1. Stay while i_grad_vld = 0. On vld&rdy, capture i_grad and go to MULT.
- MULT:
  - Register prod = (lr * grad), computed as a full 2*WIDTH signed product.
  - Shift right arithmetically by FRAC (floor; no rounding), then reduce to WIDTH.
  - Go to WRITE.
- WRITE:
  - weight[idx] <= reduce(weight[idx] - prod).
  - If idx == N-1, go to CLEAR; else idx++ and go to FETCH.
- CLEAR: o_acc_clr = 1 for exactly one cycle, then DONE.
- DONE: o_done = 1 for exactly one cycle, then IDLE.
- Latency with i_grad_vld held high: o_done is high in the cycle after the 3N+1-th rising edge following the edge that samples i_start. Each stalled FETCH cycle adds 1.
- o_grad_idx = idx at all times; stable throughout FETCH.
- Boundary conditions:
  - i_start while busy is ignored, with no restart.
  - i_init_we while busy is ignored.
  - i_init_we and i_start in the same IDLE cycle: the init write is performed and the pass starts. Index 0 uses the newly written value.
  - o_rd_w reflects a WRITE from the following cycle onward.
  - Reset mid-pass aborts immediately. No o_done or o_acc_clr is produced, and weights are zero.
  - An i_init_addr >= N write is dropped.

Optional Feature:
Macro WGHT_UPD_SAT_EN.
- Defined: reduce() saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. This applies both to the shifted product and to the subtraction result.
- Undefined: reduce() keeps the low WIDTH bits (two's-complement wrap), with no saturation logic.

Decomposition:
- Shared package wght_pkg holds:
  - state typedef (6 encodings)
  - fixed-point constants: FXP_ONE = 1<<FRAC, FXP_MAX, FXP_MIN
  - reduce/saturate function
- One natural combinational sub-module: wght_upd_alu. It takes (w, lr, grad) and performs multiply, arithmetic shift, reduce and subtract. The FSM registers the product between the MULT and WRITE stages.

Test Plan:
- N=8, init all w=0x01000000 (1.0), lr=0x00800000 (0.5), grad=0x01000000 with vld always high. All weights become 0x00800000; o_acc_clr is 1 cycle; o_done comes 3N+1=25 edges after start.
- Floor rounding: w=0, lr=0x00000001.
  - grad=0x00000001 leaves w at 0x00000000.
  - grad=0xFFFFFFFF makes w 0x00000001.
- Overflow: w=0x7F000000 (127.0), lr=0x01000000, grad=0xFE000000 (-2.0).
  - With WGHT_UPD_SAT_EN, w becomes 0x7FFFFFFF.
  - Without it, w becomes 0x81000000.
- Backpressure: drop i_grad_vld for 5 cycles while o_grad_idx=2. o_grad_rdy stays high and o_grad_idx stays 2; o_done arrives at 30 edges; weights are the same as without the stall.
- Mid-pass events:
  - i_start and i_init_we asserted during WRITE of idx 3 are ignored: no restart and the bank is unchanged.
  - rst asserted low during MULT of idx 5 returns the FSM to IDLE with all weights 0, o_busy=0, and no o_done pulse.
- Read port: i_rd_addr=7 returns weight[7]; i_rd_addr out of range (N=6, addr 7) returns 0.
